idex_pipe_reg: RTL and testbench
================================

# idex_pipe_reg

Decode-to-execute pipeline register with load-use hazard detection and stall/bubble insertion for the 8-bit RISC-RNS core. It captures decoded operands (already bypassed by the decode-stage forwarding logic), register addresses and control bits, and presents them to the EX stage and to the EX-stage forwarding logic. When a decode instruction reads the destination of a load still in EX, it holds IF/ID and the PC and injects bubbles until load data can be forwarded.

## Interface
- LOAD_STALL, 1: bubbles inserted per load-use hazard; legal range 1..3.
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- dcd_valid  in  1  decode holds a valid instruction
- op1_addr, op2_addr  in  3 each  decode source register addresses
- uses_op1, uses_op2  in  1 each  decode instruction actually reads op1 / op2
- op1_data, op2_data  in  8 each  decode operands after decode-stage bypass
- dest_addr  in  3  decode destination register
- reg_wr_en, load_true, store_true  in  1 each  decode control bits
- alu_op  in  4  ALU function; imm  in  8  immediate
- flush  in  1  taken branch resolved in EX; kill decode instruction
- ex_valid  out  1  ID/EX holds a valid instruction
- op1_addr_reg, op2_addr_reg, dest_addr_reg  out  3 each
- op1_data_reg, op2_data_reg, imm_reg  out  8 each
- reg_wr_en_reg, load_true_reg, store_true_reg  out  1 each
- alu_op_reg  out  4
- stall_ifid  out  1  hold IF/ID register and PC this cycle (combinational)
- stall_cnt  out  16  saturating stall counter (only with IDEX_PERF_CNT_EN)

## Operation
- Hazard (combinational): dcd_valid & ex_valid & load_true_reg & reg_wr_en_reg & ((uses_op1 & op1_addr==dest_addr_reg) | (uses_op2 & op2_addr==dest_addr_reg)).
- FSM states RUN, STALL; 2-bit down-counter rem.
- RUN, no hazard: capture all decode fields; ex_valid <= dcd_valid; stall_ifid=0.
- RUN, hazard: stall_ifid=1; load bubble (ex_valid, reg_wr_en_reg, load_true_reg, store_true_reg <= 0; other fields don't-care, hold previous); if LOAD_STALL==1 stay RUN, else rem <= LOAD_STALL-2, go STALL.
- STALL: stall_ifid=1; load bubble; if rem==0 go RUN, else rem <= rem-1.
- Bubble never writes registers or memory: all write-capable control bits forced 0.
- During stall, IF/ID is frozen, so decode re-reads register file each cycle; fields captured on release are the freshly bypassed values.
- flush (highest priority, any state): load bubble, state <= RUN, rem <= 0, stall_ifid=0.
- dcd_valid=0 in RUN: bubble captured, no hazard possible.

## Timing
- Reset: all outputs 0, state RUN, rem 0, stall_cnt 0.
- Latency: decode fields appear on *_reg outputs one cycle after capture edge.
- Load-use with LOAD_STALL=N: stall_ifid high exactly N consecutive cycles; dependent instruction enters ID/EX on the (N+1)th edge after hazard first seen.
- Back-to-back hazards (released instruction is itself a load used by next): new hazard detected in RUN next cycle, new stall sequence, no gap error.
- flush during STALL: stall ends same cycle; next edge captures bubble.
- rst during STALL: returns to RUN, bubble state, next edge after rst low resumes normally.
- stall_ifid depends combinationally on decode inputs and registered state; no combinational path from flush to *_reg outputs.

## Configuration
- IDEX_PERF_CNT_EN defined: stall_cnt increments on every edge where stall_ifid=1 and rst=0, saturates at 16'hFFFF, cleared by rst.
- Undefined: counter logic absent; stall_cnt tied to 16'h0000.

## Test plan
- Reset: rst=1 two cycles -> all outputs 0, stall_ifid=0; release, ADD r1,r2 (op1_data=8'h05, op2_data=8'h03) -> next cycle ex_valid=1, op1_data_reg=8'h05, op2_data_reg=8'h03.
- Load-use, LOAD_STALL=1: LD r3 in EX, decode ADD r4,r3 (uses_op2) -> stall_ifid=1 one cycle, bubble (ex_valid=0) in ID/EX, ADD captured following edge with op2_addr_reg=3.
- LOAD_STALL=3: same sequence -> stall_ifid high 3 cycles, three bubbles, then ADD captured; stall_cnt=3 with IDEX_PERF_CNT_EN.
- No false hazard: LD r3 in EX, decode instruction with op1_addr=3 but uses_op1=0 -> no stall; also non-load write to r3 -> no stall.
- flush during STALL (LOAD_STALL=3, flush in 2nd stall cycle) -> stall_ifid drops that cycle, bubble captured, state RUN.
- Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF and holds; without macro stall_cnt=0 throughout.

Source files
------------

// File: rtl/idex_pipe_reg_if.sv
// Decode-to-execute bundle: decode-stage fields in, ID/EX register contents and stall control out.
interface idex_pipe_reg_if;
   logic       dcd_valid;
   logic [2:0] op1_addr;
   logic [2:0] op2_addr;
   logic       uses_op1;
   logic       uses_op2;
   logic [7:0] op1_data;
   logic [7:0] op2_data;
   logic [2:0] dest_addr;
   logic       reg_wr_en;
   logic       load_true;
   logic       store_true;
   logic [3:0] alu_op;
   logic [7:0] imm;
   logic       flush;

   logic       ex_valid;
   logic [2:0] op1_addr_reg;
   logic [2:0] op2_addr_reg;
   logic [2:0] dest_addr_reg;
   logic [7:0] op1_data_reg;
   logic [7:0] op2_data_reg;
   logic [7:0] imm_reg;
   logic       reg_wr_en_reg;
   logic       load_true_reg;
   logic       store_true_reg;
   logic [3:0] alu_op_reg;
   logic       stall_ifid;
   logic [15:0] stall_cnt;

   modport slave (
      input  dcd_valid, op1_addr, op2_addr, uses_op1, uses_op2, op1_data, op2_data,
             dest_addr, reg_wr_en, load_true, store_true, alu_op, imm, flush,
      output ex_valid, op1_addr_reg, op2_addr_reg, dest_addr_reg, op1_data_reg,
             op2_data_reg, imm_reg, reg_wr_en_reg, load_true_reg, store_true_reg,
             alu_op_reg, stall_ifid, stall_cnt
   );

   modport master (
      output dcd_valid, op1_addr, op2_addr, uses_op1, uses_op2, op1_data, op2_data,
             dest_addr, reg_wr_en, load_true, store_true, alu_op, imm, flush,
      input  ex_valid, op1_addr_reg, op2_addr_reg, dest_addr_reg, op1_data_reg,
             op2_data_reg, imm_reg, reg_wr_en_reg, load_true_reg, store_true_reg,
             alu_op_reg, stall_ifid, stall_cnt
   );
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with load-use stall/bubble insertion.
// Optional saturating stall counter enabled by defining IDEX_PERF_CNT_EN.
module idex_pipe_reg #(
   parameter int LOAD_STALL = 1
) (
   input  logic           clk,
   input  logic           rst,
   idex_pipe_reg_if.slave bus
);
   if (LOAD_STALL < 1 || LOAD_STALL > 3) begin : g_bad_load_stall
      $error("LOAD_STALL must be in 1..3");
   end

   // Down-counter preload: the RUN cycle that detects the hazard is the first bubble.
   localparam logic [1:0] REM_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

   typedef enum logic {RUN, STALL} state_e;

   state_e     state_q;
   logic [1:0] rem_q;
   logic       ex_valid_q;
   logic [2:0] op1_addr_q, op2_addr_q, dest_addr_q;
   logic [7:0] op1_data_q, op2_data_q, imm_q;
   logic       reg_wr_en_q, load_true_q, store_true_q;
   logic [3:0] alu_op_q;
   logic       hazard;
   logic       stall_ifid;

   assign hazard = bus.dcd_valid & ex_valid_q & load_true_q & reg_wr_en_q &
                   ((bus.uses_op1 & (bus.op1_addr == dest_addr_q)) |
                    (bus.uses_op2 & (bus.op2_addr == dest_addr_q)));

   assign stall_ifid = ~bus.flush & ((state_q == STALL) | hazard);

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         rem_q        <= 2'd0;
         ex_valid_q   <= 1'b0;
         op1_addr_q   <= 3'd0;
         op2_addr_q   <= 3'd0;
         dest_addr_q  <= 3'd0;
         op1_data_q   <= 8'd0;
         op2_data_q   <= 8'd0;
         imm_q        <= 8'd0;
         reg_wr_en_q  <= 1'b0;
         load_true_q  <= 1'b0;
         store_true_q <= 1'b0;
         alu_op_q     <= 4'd0;
      end else if (bus.flush) begin
         state_q      <= RUN;
         rem_q        <= 2'd0;
         ex_valid_q   <= 1'b0;
         reg_wr_en_q  <= 1'b0;
         load_true_q  <= 1'b0;
         store_true_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (hazard) begin
                  ex_valid_q   <= 1'b0;
                  reg_wr_en_q  <= 1'b0;
                  load_true_q  <= 1'b0;
                  store_true_q <= 1'b0;
                  if (LOAD_STALL > 1) begin
                     rem_q   <= REM_INIT;
                     state_q <= STALL;
                  end
               end else begin
                  // An invalid decode slot still lands as a bubble with write controls cleared.
                  ex_valid_q   <= bus.dcd_valid;
                  op1_addr_q   <= bus.op1_addr;
                  op2_addr_q   <= bus.op2_addr;
                  dest_addr_q  <= bus.dest_addr;
                  op1_data_q   <= bus.op1_data;
                  op2_data_q   <= bus.op2_data;
                  imm_q        <= bus.imm;
                  reg_wr_en_q  <= bus.dcd_valid & bus.reg_wr_en;
                  load_true_q  <= bus.dcd_valid & bus.load_true;
                  store_true_q <= bus.dcd_valid & bus.store_true;
                  alu_op_q     <= bus.alu_op;
               end
            end
            STALL: begin
               ex_valid_q   <= 1'b0;
               reg_wr_en_q  <= 1'b0;
               load_true_q  <= 1'b0;
               store_true_q <= 1'b0;
               if (rem_q == 2'd0) state_q <= RUN;
               else               rem_q   <= rem_q - 2'd1;
            end
            default: state_q <= RUN;
         endcase
      end
   end

`ifdef IDEX_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_ifid && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= 16'd0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = 16'h0000;
`endif

   assign bus.stall_ifid     = stall_ifid;
   assign bus.ex_valid       = ex_valid_q;
   assign bus.op1_addr_reg   = op1_addr_q;
   assign bus.op2_addr_reg   = op2_addr_q;
   assign bus.dest_addr_reg  = dest_addr_q;
   assign bus.op1_data_reg   = op1_data_q;
   assign bus.op2_data_reg   = op2_data_q;
   assign bus.imm_reg        = imm_q;
   assign bus.reg_wr_en_reg  = reg_wr_en_q;
   assign bus.load_true_reg  = load_true_q;
   assign bus.store_true_reg = store_true_q;
   assign bus.alu_op_reg     = alu_op_q;
endmodule

// File: tb/tb_idex_pipe_reg.sv
// Scoreboard bench for idex_pipe_reg: one instance with LOAD_STALL=1, one with LOAD_STALL=3.
module tb_idex_pipe_reg;
   typedef struct packed {
      logic       valid;
      logic [2:0] a1, a2, dst;
      logic [7:0] d1, d2, imm;
      logic       wr, ld, st;
      logic [3:0] alu;
      logic       u1, u2;
   } instr_t;

   typedef struct {
      logic        cap;
      logic [40:0] f;
      string       tag;
   } exp_t;

   localparam logic [40:0] BMASK = (41'd1 << 40) | 41'h70;

   logic   clk = 1'b0;
   logic   rst;
   logic   flush;
   logic   sel;
   instr_t cur;
   exp_t   sb[$];
   int     n_checks = 0;
   int     n_err = 0;
   int     model_cnt = 0;

   always #5 clk = ~clk;

   idex_pipe_reg_if if1 ();
   idex_pipe_reg_if if3 ();

   idex_pipe_reg #(.LOAD_STALL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   idex_pipe_reg #(.LOAD_STALL(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   always_comb begin
      if1.dcd_valid = cur.valid;  if3.dcd_valid = cur.valid;
      if1.op1_addr  = cur.a1;     if3.op1_addr  = cur.a1;
      if1.op2_addr  = cur.a2;     if3.op2_addr  = cur.a2;
      if1.uses_op1  = cur.u1;     if3.uses_op1  = cur.u1;
      if1.uses_op2  = cur.u2;     if3.uses_op2  = cur.u2;
      if1.op1_data  = cur.d1;     if3.op1_data  = cur.d1;
      if1.op2_data  = cur.d2;     if3.op2_data  = cur.d2;
      if1.dest_addr = cur.dst;    if3.dest_addr = cur.dst;
      if1.reg_wr_en = cur.wr;     if3.reg_wr_en = cur.wr;
      if1.load_true = cur.ld;     if3.load_true = cur.ld;
      if1.store_true = cur.st;    if3.store_true = cur.st;
      if1.alu_op    = cur.alu;    if3.alu_op    = cur.alu;
      if1.imm       = cur.imm;    if3.imm       = cur.imm;
      if1.flush     = flush;      if3.flush     = flush;
   end

   logic [40:0] f1, f3, obs_f;
   logic        obs_stall;
   logic [15:0] obs_cnt;

   assign f1 = {if1.ex_valid, if1.op1_addr_reg, if1.op2_addr_reg, if1.dest_addr_reg,
                if1.op1_data_reg, if1.op2_data_reg, if1.imm_reg, if1.reg_wr_en_reg,
                if1.load_true_reg, if1.store_true_reg, if1.alu_op_reg};
   assign f3 = {if3.ex_valid, if3.op1_addr_reg, if3.op2_addr_reg, if3.dest_addr_reg,
                if3.op1_data_reg, if3.op2_data_reg, if3.imm_reg, if3.reg_wr_en_reg,
                if3.load_true_reg, if3.store_true_reg, if3.alu_op_reg};
   assign obs_f     = sel ? f3 : f1;
   assign obs_stall = sel ? if3.stall_ifid : if1.stall_ifid;
   assign obs_cnt   = sel ? if3.stall_cnt : if1.stall_cnt;

   function automatic logic [40:0] pack_instr(input instr_t i);
      return {i.valid, i.a1, i.a2, i.dst, i.d1, i.d2, i.imm, i.wr, i.ld, i.st, i.alu};
   endfunction

   function automatic logic [15:0] exp_cnt();
`ifdef IDEX_PERF_CNT_EN
      return (model_cnt > 65535) ? 16'hFFFF : 16'(model_cnt);
`else
      return 16'h0000;
`endif
   endfunction

   function automatic instr_t mk(input logic valid, input logic [2:0] a1, input logic u1,
                                 input logic [2:0] a2, input logic u2, input logic [2:0] dst,
                                 input logic [7:0] d1, input logic [7:0] d2, input logic wr,
                                 input logic ld, input logic [3:0] alu, input logic [7:0] imm);
      instr_t i;
      i.valid = valid; i.a1 = a1; i.u1 = u1; i.a2 = a2; i.u2 = u2; i.dst = dst;
      i.d1 = d1; i.d2 = d2; i.wr = wr; i.ld = ld; i.st = 1'b0; i.alu = alu; i.imm = imm;
      return i;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one decode slot, check the combinational stall, then check the ID/EX result after the edge.
   task automatic step(input string tag, input instr_t ins, input logic fl,
                       input logic exp_stall, input logic exp_cap);
      exp_t e;
      cur   = ins;
      flush = fl;
      #1;
      check({tag, "/stall"}, 64'(obs_stall), 64'(exp_stall));
      e.cap = exp_cap & ins.valid & ~fl;
      e.f   = pack_instr(ins);
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (exp_stall) model_cnt++;
      e = sb.pop_front();
      if (e.cap) check({e.tag, "/fields"}, 64'(obs_f), 64'(e.f));
      else       check({e.tag, "/bubble"}, 64'(obs_f & BMASK), 64'd0);
      check({e.tag, "/cnt"}, 64'(obs_cnt), 64'(exp_cnt()));
   endtask

   task automatic do_reset(input string tag);
      flush = 1'b0;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check({tag, "/rst_fields"}, 64'(obs_f), 64'd0);
      check({tag, "/rst_stall"}, 64'(obs_stall), 64'd0);
      check({tag, "/rst_cnt"}, 64'(obs_cnt), 64'd0);
      rst       = 1'b0;
      model_cnt = 0;
   endtask

   instr_t nop, add12, ld3, use3, use3b, ldr3, addi3, use3a1;

   initial begin
      nop    = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 4'h0, 8'h00);
      add12  = mk(1, 3'd1, 1, 3'd2, 1, 3'd1, 8'h05, 8'h03, 1, 0, 4'h1, 8'h00);
      ld3    = mk(1, 3'd1, 1, 3'd0, 0, 3'd3, 8'h40, 8'h00, 1, 1, 4'h0, 8'h04);
      use3   = mk(1, 3'd1, 1, 3'd3, 1, 3'd4, 8'h22, 8'h11, 1, 0, 4'h1, 8'h00);
      use3b  = mk(1, 3'd1, 1, 3'd3, 1, 3'd4, 8'h22, 8'hA5, 1, 0, 4'h1, 8'h00);
      ldr3   = mk(1, 3'd3, 1, 3'd0, 0, 3'd3, 8'h5A, 8'h00, 1, 1, 4'h0, 8'h01);
      addi3  = mk(1, 3'd3, 0, 3'd0, 0, 3'd3, 8'h77, 8'h00, 1, 0, 4'h2, 8'h09);
      use3a1 = mk(1, 3'd3, 1, 3'd5, 1, 3'd6, 8'h31, 8'h13, 1, 0, 4'h3, 8'h00);

      // LOAD_STALL = 1 instance
      sel = 1'b0;
      cur = nop;
      do_reset("r1");
      step("add",       add12, 0, 0, 1);
      step("ld1",       ld3,   0, 0, 1);
      step("lu1_stall", use3,  0, 1, 0);
      step("lu1_rel",   use3b, 0, 0, 1);
      step("b2b_ld",    ld3,   0, 0, 1);
      step("b2b_st1",   ldr3,  0, 1, 0);
      step("b2b_rel1",  ldr3,  0, 0, 1);
      step("b2b_st2",   use3b, 0, 1, 0);
      step("b2b_rel2",  use3b, 0, 0, 1);
      step("nf_ld",     ld3,   0, 0, 1);
      step("nf_nouse",  addi3, 0, 0, 1);
      step("nf_nonld",  use3a1, 0, 0, 1);
      step("nop1",      nop,   0, 0, 1);

      // LOAD_STALL = 3 instance
      sel = 1'b1;
      cur = nop;
      do_reset("r3");
      step("l3_ld",     ld3,   0, 0, 1);
      for (int i = 0; i < 3; i++) step("l3_stall", use3, 0, 1, 0);
      step("l3_rel",    use3b, 0, 0, 1);
      step("fl_ld",     ld3,   0, 0, 1);
      step("fl_st1",    use3,  0, 1, 0);
      step("fl_flush",  use3,  1, 0, 0);
      step("fl_rel",    use3b, 0, 0, 1);
      step("rs_ld",     ld3,   0, 0, 1);
      step("rs_st1",    use3,  0, 1, 0);
      step("rs_st2",    use3,  0, 1, 0);
      do_reset("rs_mid");
      step("rs_rel",    use3b, 0, 0, 1);
      step("nop3",      nop,   0, 0, 1);

`ifdef IDEX_PERF_CNT_EN
      cur = nop;
      do_reset("sat");
      step("sat_ld", ldr3, 0, 0, 1);
      while (model_cnt < 65540) begin
         for (int i = 0; i < 3; i++) step("sat_st", ldr3, 0, 1, 0);
         step("sat_rel", ldr3, 0, 0, 1);
      end
      step("sat_hold", nop, 0, 0, 1);
      check("sat_final", 64'(obs_cnt), 64'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
